// File: rtl/gf64_tower_power_seq.sv
// Multi-lane sequential power map y = x^e over GF(64) in tower form GF((2^2)^3).
// Square-and-multiply, MSB-first, one exponent bit per cycle, valid/ready handshake.
// Operands and results stay in tower representation throughout.
module gf64_tower_power_seq #(
  parameter int unsigned LANES     = 1,
  parameter int unsigned USE_FIXED = 0,
  parameter int unsigned FIXED_EXP = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6*LANES-1:0] in_x,
  input  logic [5:0]         in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6*LANES-1:0] out_y,
  output logic               busy
);

  localparam int unsigned W        = 6 * LANES;
  localparam logic [5:0]  FixedExp = 6'(FIXED_EXP);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   x_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   step;
  logic [W-1:0]   out_y_q;
  logic           out_valid_q;
  logic [5:0]     e_q;
  logic [2:0]     idx_q;

  // GF(4), normal basis {w, w^2}: bit0 = coeff of w, 1 = 2'b11.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic t;
    t = (a[0] & b[1]) ^ (a[1] & b[0]);
    return {(a[0] & b[0]) ^ t, (a[1] & b[1]) ^ t};
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic logic [1:0] gf4_mulw(input logic [1:0] a);
    return {a[0] ^ a[1], a[1]};
  endfunction

  // GF(64) = GF(4)[z]/(z^3 + w); z^3 folds back as w, z^4 as w*z.
  function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
    logic [1:0] c0, c1, c2;
    c0 = gf4_mul(a[1:0], b[1:0])
       ^ gf4_mulw(gf4_mul(a[3:2], b[5:4]) ^ gf4_mul(a[5:4], b[3:2]));
    c1 = gf4_mul(a[1:0], b[3:2]) ^ gf4_mul(a[3:2], b[1:0])
       ^ gf4_mulw(gf4_mul(a[5:4], b[5:4]));
    c2 = gf4_mul(a[1:0], b[5:4]) ^ gf4_mul(a[3:2], b[3:2]) ^ gf4_mul(a[5:4], b[1:0]);
    return {c2, c1, c0};
  endfunction

  // Frobenius is linear: no multiplier needed for squaring.
  function automatic logic [5:0] gf64_sq(input logic [5:0] a);
    return {gf4_sq(a[3:2]), gf4_mulw(gf4_sq(a[5:4])), gf4_sq(a[1:0])};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid)       state_d = StRun;
      StRun:   if (idx_q == 3'd0)  state_d = StDone;
      StDone:  if (out_ready)      state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  // Handshake/status outputs decoded from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  // One square-and-multiply step per lane; all lanes share the current exponent bit.
  always_comb begin
    step = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      step[6*k +: 6] = gf64_mul(gf64_sq(acc_q[6*k +: 6]),
                                e_q[idx_q] ? x_q[6*k +: 6] : 6'h03);
    end
  end

  // Datapath registers: operand latch, accumulator, bit index and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      e_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q   <= in_x;
            e_q   <= (USE_FIXED != 0) ? FixedExp : in_exp;
            acc_q <= {LANES{6'h03}};
            idx_q <= 3'd5;
          end
        end
        StRun: begin
          acc_q <= step;
          idx_q <= idx_q - 3'd1;
          if (idx_q == 3'd0) begin
            out_y_q     <= step;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gf64_tower_power_seq.sv
// Self-checking bench for gf64_tower_power_seq: one single-lane runtime-exponent
// instance and one two-lane fixed-exponent (26) instance, scoreboard per instance.
module tb_gf64_tower_power_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [5:0]  in_x0, in_exp0, out_y0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [11:0] in_x1, out_y1;
  logic [5:0]  in_exp1;

  int checks   = 0;
  int failures = 0;

  logic [5:0]  q0[$];
  logic [11:0] q1[$];

  gf64_tower_power_seq #(.LANES(1), .USE_FIXED(0), .FIXED_EXP(26)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_x(in_x0),
    .in_exp(in_exp0), .out_valid(out_valid0), .out_ready(out_ready0), .out_y(out_y0),
    .busy(busy0)
  );

  gf64_tower_power_seq #(.LANES(2), .USE_FIXED(1), .FIXED_EXP(26)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_x(in_x1),
    .in_exp(in_exp1), .out_valid(out_valid1), .out_ready(out_ready1), .out_y(out_y1),
    .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference GF(4) multiply via discrete logs: 1=11 (w^0), w=01, w^2=10.
  function automatic int gf4_log(input logic [1:0] a);
    case (a)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] ref_gf4_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    case ((gf4_log(a) + gf4_log(b)) % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Schoolbook product then reduce with z^3 = w.
  function automatic logic [5:0] ref_gf64_mul(input logic [5:0] a, input logic [5:0] b);
    logic [1:0] p [0:4];
    for (int i = 0; i < 5; i++) p[i] = 2'b00;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i+j] = p[i+j] ^ ref_gf4_mul(a[2*i +: 2], b[2*j +: 2]);
    p[0] = p[0] ^ ref_gf4_mul(p[3], 2'b01);
    p[1] = p[1] ^ ref_gf4_mul(p[4], 2'b01);
    return {p[2], p[1], p[0]};
  endfunction

  function automatic logic [5:0] model_pow(input logic [5:0] x, input logic [5:0] e);
    logic [5:0] r;
    r = 6'h03;
    for (int i = 0; i < int'(e); i++) r = ref_gf64_mul(r, x);
    return r;
  endfunction

  // Scoreboard monitors: a result is consumed on the edge after out_valid&out_ready is seen.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      if (q0.size() == 0) check_eq("sb0_underflow", 12'(out_valid0), 12'd0);
      else check_eq("y0", 12'(out_y0), 12'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check_eq("sb1_underflow", 12'(out_valid1), 12'd0);
      else check_eq("y1", out_y1, q1.pop_front());
    end
  end

  task automatic start0(input logic [5:0] x, input logic [5:0] e, input logic [5:0] exp);
    @(negedge clk);
    check_eq("in_ready0_idle", 12'(in_ready0), 12'd1);
    in_valid0 = 1'b1;
    in_x0     = x;
    in_exp0   = e;
    q0.push_back(exp);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    check_eq("busy0_run", 12'(busy0), 12'd1);
  endtask

  task automatic wait0(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid0 && cyc < 20);
    if (!out_valid0) check_eq("timeout0", 12'(out_valid0), 12'd1);
  endtask

  // Negedge count 7 after the accept edge == out_valid rose on the 6th edge after it.
  task automatic op0(input logic [5:0] x, input logic [5:0] e, input logic [5:0] exp,
                     input bit chk_lat);
    int cyc;
    start0(x, e, exp);
    wait0(cyc);
    if (chk_lat) check_eq("lat0", 12'(cyc), 12'd7);
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input logic [11:0] x, input logic [11:0] exp, input bit chk_lat);
    int cyc;
    @(negedge clk);
    check_eq("in_ready1_idle", 12'(in_ready1), 12'd1);
    in_valid1 = 1'b1;
    in_x1     = x;
    in_exp1   = 6'($urandom);
    q1.push_back(exp);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid1 && cyc < 20);
    if (!out_valid1) check_eq("timeout1", 12'(out_valid1), 12'd1);
    if (chk_lat) check_eq("lat1", 12'(cyc), 12'd7);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic [11:0] rx;
    rst = 1'b1;
    in_valid0 = 1'b0; in_x0 = '0; in_exp0 = '0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_x1 = '0; in_exp1 = '0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid0", 12'(out_valid0), 12'd0);
    check_eq("rst_out_y0",     12'(out_y0),     12'd0);
    check_eq("rst_busy0",      12'(busy0),      12'd0);
    check_eq("rst_out_valid1", 12'(out_valid1), 12'd0);
    check_eq("rst_out_y1",     out_y1,          12'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready0", 12'(in_ready0), 12'd1);
    check_eq("rst_in_ready1", 12'(in_ready1), 12'd1);

    // Directed values from the known tower-field results.
    op0(6'h0C, 6'd3,  6'h01, 1'b1);
    op0(6'h0C, 6'd0,  6'h03, 1'b1);
    op0(6'h0C, 6'd1,  6'h0C, 1'b0);
    op0(6'h0C, 6'd6,  6'h02, 1'b0);
    op0(6'h0C, 6'd62, 6'h20, 1'b0);
    op0(6'h00, 6'd0,  6'h03, 1'b0);
    op0(6'h00, 6'd5,  6'h00, 1'b0);

    // Two lanes, fixed exponent 26; in_exp is driven randomly and must be ignored.
    op1({6'h03, 6'h0C}, {6'h03, 6'h20}, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rx = 12'($urandom);
      op1(rx, {model_pow(rx[11:6], 6'd26), model_pow(rx[5:0], 6'd26)}, 1'b0);
    end

    // Backpressure: result held, no second acceptance while DONE.
    out_ready0 = 1'b0;
    start0(6'h0C, 6'd3, 6'h01);
    wait0(cyc);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        in_valid0 = 1'b1;
        in_x0     = 6'h15;
        in_exp0   = 6'd9;
      end
      check_eq("bp_out_y0",     12'(out_y0),     12'h001);
      check_eq("bp_out_valid0", 12'(out_valid0), 12'd1);
      check_eq("bp_in_ready0",  12'(in_ready0),  12'd0);
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    @(posedge clk);
    #1 out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release_in_ready0",  12'(in_ready0),  12'd1);
    check_eq("bp_release_out_valid0", 12'(out_valid0), 12'd0);
    op0(6'h15, 6'd9, model_pow(6'h15, 6'd9), 1'b1);

    // Reset in the third RUN cycle aborts the operation.
    start0(6'h0C, 6'd3, 6'h01);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_out_valid0", 12'(out_valid0), 12'd0);
    check_eq("abort_out_y0",     12'(out_y0),     12'd0);
    check_eq("abort_busy0",      12'(busy0),      12'd0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    op0(6'h0C, 6'd6, 6'h02, 1'b1);

    // Full 64x64 sweep against the reference model, then x^63 = 1 for x != 0.
    for (int x = 0; x < 64; x++)
      for (int e = 0; e < 64; e++)
        op0(6'(x), 6'(e), model_pow(6'(x), 6'(e)), 1'b0);
    for (int x = 1; x < 64; x++) op0(6'(x), 6'd63, 6'h03, 1'b0);

    repeat (4) @(negedge clk);
    check_eq("sb0_drain", 12'(q0.size()), 12'd0);
    check_eq("sb1_drain", 12'(q1.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
